// File: rtl/one_hot_pkg.sv
// Shared one-hot helpers and default sizing for the one-hot mux/demux family.
package one_hot_pkg;

  localparam int unsigned ONE_HOT_WIDTH   = 32;
  localparam int unsigned ONE_HOT_CNT     = 5;
  // Widest select vector the shared checker handles; narrower vectors are zero-extended.
  localparam int unsigned ONE_HOT_MAX_CNT = 64;

  // True when exactly one bit is set: rejects both all-zero and multi-hot vectors.
  function automatic logic is_one_hot(input logic [ONE_HOT_MAX_CNT-1:0] vec);
    return (vec != '0) && ((vec & (vec - ONE_HOT_MAX_CNT'(1))) == '0);
  endfunction

endpackage

// File: rtl/one_hot_chk.sv
// Combinational one-hot legality check on a select vector.
module one_hot_chk
  import one_hot_pkg::*;
#(
  parameter int unsigned CNT = ONE_HOT_CNT
) (
  input  logic [CNT-1:0] vec,
  output logic           legal,
  output logic           zero
);

  // Zero-extension preserves one-hotness, so the shared wide checker applies directly.
  assign legal = is_one_hot(ONE_HOT_MAX_CNT'(vec));
  assign zero  = (vec == '0);

endmodule

// File: rtl/one_hot_demux.sv
// Registered one-hot demultiplexer: one input beat steered to one of CNT destinations,
// with per-destination back-pressure and counting of illegal selects.
module one_hot_demux
  import one_hot_pkg::*;
#(
  parameter int unsigned WIDTH = ONE_HOT_WIDTH,
  parameter int unsigned CNT   = ONE_HOT_CNT,
  parameter int unsigned ERRW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic [CNT-1:0]       din_sel,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic [WIDTH*CNT-1:0] dout,
  output logic [CNT-1:0]       dout_vld,
  input  logic [CNT-1:0]       dout_rdy,
  output logic                 err,
  output logic [ERRW-1:0]      err_cnt
);

  logic             hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CNT-1:0]   hold_sel_q, hold_sel_d;
  logic             err_q, err_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

  logic sel_legal;
  logic unused_sel_zero;
  logic drain;
  logic accept;

  one_hot_chk #(
    .CNT (CNT)
  ) u_sel_chk (
    .vec   (din_sel),
    .legal (sel_legal),
    .zero  (unused_sel_zero)
  );

  // Handshake: only the selected destination's ready can free the holding slot.
  always_comb begin
    drain   = hold_vld_q & (|(hold_sel_q & dout_rdy));
    din_rdy = ~hold_vld_q | drain;
    accept  = din_vld & din_rdy;
  end

  // Next state: a legal beat refills the slot (same edge as drain, no bubble);
  // an illegal beat is swallowed and only bumps the error pulse and counter.
  always_comb begin
    hold_vld_d  = hold_vld_q & ~drain;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      if (sel_legal) begin
        hold_vld_d  = 1'b1;
        hold_data_d = din;
        hold_sel_d  = din_sel;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != {ERRW{1'b1}}) begin
          err_cnt_d = err_cnt_q + ERRW'(1);
        end
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Outputs come straight from registers; unselected slices read zero.
  always_comb begin
    dout_vld = {CNT{hold_vld_q}} & hold_sel_q;
    err      = err_q;
    err_cnt  = err_cnt_q;
    dout     = '0;
    for (int i = 0; i < int'(CNT); i++) begin
      dout[i*WIDTH +: WIDTH] = hold_data_q & {WIDTH{dout_vld[i]}};
    end
  end

endmodule

// File: tb/tb_one_hot_demux.sv
// Scoreboard bench for one_hot_demux: driver pushes expected beats, monitor pops and compares.
module tb_one_hot_demux;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT   = 5;
  localparam int unsigned ERRW  = 8;
  localparam int          CNT_MAX = 255;

  typedef struct packed {
    logic [CNT-1:0]   sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic                 clk;
  logic                 rst_n;
  logic [WIDTH-1:0]     din;
  logic [CNT-1:0]       din_sel;
  logic                 din_vld;
  logic                 din_rdy;
  logic [WIDTH*CNT-1:0] dout;
  logic [CNT-1:0]       dout_vld;
  logic [CNT-1:0]       dout_rdy;
  logic                 err;
  logic [ERRW-1:0]      err_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of beats in flight (front = beat held at the output),
  // pending error pulse and saturating illegal count.
  beat_t sb[$];
  logic  err_pend  = 1'b0;
  int    model_cnt = 0;

  logic                 stall_prev = 1'b0;
  logic [WIDTH*CNT-1:0] prev_dout;
  logic [CNT-1:0]       prev_vld;

  one_hot_demux #(
    .WIDTH (WIDTH),
    .CNT   (CNT),
    .ERRW  (ERRW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_sel  (din_sel),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [WIDTH*CNT-1:0] act,
                       input logic [WIDTH*CNT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH*CNT-1:0] pack_beat(input beat_t b);
    logic [WIDTH*CNT-1:0] v;
    v = '0;
    for (int i = 0; i < int'(CNT); i++) begin
      if (b.sel[i]) v[i*WIDTH +: WIDTH] = b.data;
    end
    return v;
  endfunction

  // Monitor: sample mid-low-phase, compare against the scoreboard front, pop on handshake.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        b = sb[0];
        check("dout_vld", {{(WIDTH*CNT-CNT){1'b0}}, dout_vld}, {{(WIDTH*CNT-CNT){1'b0}}, b.sel});
        check("dout", dout, pack_beat(b));
        if ((b.sel & dout_rdy) != '0) void'(sb.pop_front());
      end else begin
        check("dout_vld_idle", {{(WIDTH*CNT-CNT){1'b0}}, dout_vld}, '0);
        check("dout_idle", dout, '0);
      end
      check("err", {{(WIDTH*CNT-1){1'b0}}, err}, {{(WIDTH*CNT-1){1'b0}}, err_pend});
      err_pend = 1'b0;
      check("err_cnt", {{(WIDTH*CNT-ERRW){1'b0}}, err_cnt},
            {{(WIDTH*CNT-ERRW){1'b0}}, ERRW'(model_cnt)});
      if (rst_n && stall_prev) begin
        check("stable_dout", dout, prev_dout);
        check("stable_vld", {{(WIDTH*CNT-CNT){1'b0}}, dout_vld},
              {{(WIDTH*CNT-CNT){1'b0}}, prev_vld});
      end
      stall_prev = rst_n && (dout_vld != '0) && ((dout_vld & dout_rdy) == '0);
      prev_dout  = dout;
      prev_vld   = dout_vld;
    end
  end

  // Driver: one beat per cycle; acceptance decided from the model's view of the slot.
  task automatic cycle(input logic vld, input logic [CNT-1:0] sel, input logic [WIDTH-1:0] data,
                       input logic [CNT-1:0] rdy);
    logic exp_rdy;
    @(negedge clk);
    din_vld  = vld;
    din_sel  = sel;
    din      = data;
    dout_rdy = rdy;
    #6;
    // Monitor has already popped a draining beat, so an empty queue means room.
    exp_rdy = (sb.size() == 0);
    check("din_rdy", {{(WIDTH*CNT-1){1'b0}}, din_rdy}, {{(WIDTH*CNT-1){1'b0}}, exp_rdy});
    if (rst_n && vld && exp_rdy) begin
      if ($countones(sel) == 1) begin
        sb.push_back('{sel: sel, data: data});
      end else begin
        err_pend = 1'b1;
        if (model_cnt < CNT_MAX) model_cnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '1);
  endtask

  initial begin
    logic [CNT-1:0] s;
    rst_n    = 1'b0;
    din      = '0;
    din_sel  = '0;
    din_vld  = 1'b0;
    dout_rdy = '1;

    // Reset then idle.
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single beat to destination 2.
    cycle(1'b1, 5'b00100, 32'hDEADBEEF, '1);
    idle(2);

    // Back-pressure on destination 1 with a second beat waiting.
    cycle(1'b1, 5'b00010, 32'h1111_AAAA, 5'b11101);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'b00010, 32'h2222_BBBB, 5'b11101);
    cycle(1'b1, 5'b00010, 32'h2222_BBBB, '1);
    idle(2);

    // Illegal selects: zero, multi-hot, and an illegal select without valid.
    cycle(1'b1, 5'b00000, 32'h0BAD_0000, '1);
    cycle(1'b1, 5'b01010, 32'h0BAD_0001, '1);
    cycle(1'b0, 5'b11111, 32'h0BAD_0002, '1);
    idle(2);
    for (int i = 0; i < 300; i++) begin
      s = CNT'($urandom);
      if ($countones(s) == 1) s = '0;
      cycle(1'b1, s, $urandom, '1);
    end
    idle(2);
    check("err_cnt_sat", {{(WIDTH*CNT-ERRW){1'b0}}, err_cnt}, {{(WIDTH*CNT-ERRW){1'b0}}, 8'hFF});

    // Streaming with rotating select and all destinations ready.
    for (int i = 0; i < 100; i++) cycle(1'b1, CNT'(1) << (i % 5), $urandom, '1);
    idle(2);

    // Asynchronous reset while a beat is held.
    cycle(1'b1, 5'b00001, 32'hCAFE_F00D, '0);
    cycle(1'b0, '0, '0, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    err_pend   = 1'b0;
    model_cnt  = 0;
    stall_prev = 1'b0;
    #1;
    check("rst_dout_vld", {{(WIDTH*CNT-CNT){1'b0}}, dout_vld}, '0);
    check("rst_dout", dout, '0);
    check("rst_err_cnt", {{(WIDTH*CNT-ERRW){1'b0}}, err_cnt}, '0);
    check("rst_din_rdy", {{(WIDTH*CNT-1){1'b0}}, din_rdy}, {{(WIDTH*CNT-1){1'b0}}, 1'b1});
    cycle(1'b0, '0, '0, '1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Random traffic: mostly legal selects, occasional illegal, random ready.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) s = CNT'($urandom);
      else s = CNT'(1) << $urandom_range(CNT - 1);
      cycle(($urandom_range(3) != 0), s, $urandom, CNT'($urandom | $urandom));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
